// File: rtl/fifo_pkg.sv
// Shared types for the byte-FIFO producer/consumer blocks.
package fifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, SEND, HALT} wr_state_e;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/fifo_credit_ctr.sv
// Free-slot credit counter for a FIFO producer. The count drops when the
// producer issues a write and rises when the consumer reads. A read seen
// while the FIFO is already empty (credits full) is an underflow and
// returns nothing, so the count stays within 0..FIFO_DEPTH.
module fifo_credit_ctr #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             rd_n,
  input  logic             load,
  output logic [CNT_W-1:0] credits,
  output logic             zero
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] credits_q, credits_d;
  logic             ret, take;

  assign zero = (credits_q == '0);
  assign ret  = !rd_n && (credits_q != FULL);
  assign take = issue && !zero;

  // Next count: reload wins, otherwise net of one write and one read.
  always_comb begin
    credits_d = credits_q;
    if (load) begin
      credits_d = FULL;
    end else if (take && !ret) begin
      credits_d = credits_q - ONE;
    end else if (ret && !take) begin
      credits_d = credits_q + ONE;
    end
  end

  // Credit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= FULL;
    end else begin
      credits_q <= credits_d;
    end
  end

  assign credits = credits_q;

endmodule

// File: rtl/fifo_wr_serializer.sv
// Word-to-byte write stage in front of the byte FIFO. Splits each accepted
// word into bytes, gates writes on local credits, and halts on FIFO overflow
// until err_clr.
// Build option: define FIFO_WR_MSB_FIRST_EN to emit the most significant
// byte first; default order is least significant byte first.
//
// state | meaning
// IDLE  | ready for a new word (s_ready=1)
// SEND  | emitting bytes of the latched word, stalls while credits are 0
// HALT  | overflow seen, no writes until err_clr
module fifo_wr_serializer
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [8*WORD_BYTES-1:0]           s_data,
  output logic                              wr_n,
  output logic [7:0]                        din,
  input  logic                              fifo_rd_n,
  input  logic                              over_flow,
  input  logic                              err_clr,
  output logic                              err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   credits
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  wr_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              wr_n_q, wr_n_d;
  byte_t             din_q, din_d;
  logic              err_q, err_d;
  logic              issue, reload, no_credit;
  byte_t             sel_byte;

  fifo_credit_ctr #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue),
    .rd_n    (fifo_rd_n),
    .load    (reload),
    .credits (credits),
    .zero    (no_credit)
  );

  // Pick the byte for the current index in the configured order.
  always_comb begin
`ifdef FIFO_WR_MSB_FIRST_EN
    sel_byte = byte_t'(word_q >> (BYTE_W * (WORD_BYTES - 1 - int'(idx_q))));
`else
    sel_byte = byte_t'(word_q >> (BYTE_W * int'(idx_q)));
`endif
  end

  // Next-state and output logic; overflow overrides everything else.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wr_n_d  = 1'b1;
    din_d   = din_q;
    err_d   = err_q;
    issue   = 1'b0;
    reload  = 1'b0;
    if (over_flow) begin
      state_d = HALT;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            word_d  = s_data;
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (!no_credit) begin
            issue  = 1'b1;
            wr_n_d = 1'b0;
            din_d  = sel_byte;
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_d = IDLE;
          end
        end
        HALT: begin
          if (err_clr) begin
            state_d = IDLE;
            err_d   = 1'b0;
            reload  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      wr_n_q  <= 1'b1;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wr_n_q  <= wr_n_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign wr_n    = wr_n_q;
  assign din     = din_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Directed bench for fifo_wr_serializer: expected bytes are queued when a
// word is driven and a monitor checks each FIFO write against the queue.
module tb_fifo_wr_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        wr_n;
  logic [7:0]  din;
  logic        fifo_rd_n = 1'b1;
  logic        over_flow = 1'b0;
  logic        err_clr = 1'b0;
  logic        err;
  logic [4:0]  credits;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int base;
  int lat;
  logic [7:0] exp_q[$];

  fifo_wr_serializer #(.FIFO_DEPTH(16), .WORD_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .wr_n      (wr_n),
    .din       (din),
    .fifo_rd_n (fifo_rd_n),
    .over_flow (over_flow),
    .err_clr   (err_clr),
    .err       (err),
    .credits   (credits)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
`ifdef FIFO_WR_MSB_FIRST_EN
    return w[31 - 8*i -: 8];
`else
    return w[8*i +: 8];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued byte.
  always @(negedge clk) begin
    if (rst_n && wr_n === 1'b0) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got din %0h expected no write", din);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (din !== e) begin
          bad++;
          $display("FAIL write_data: got %0h expected %0h", din, e);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    fifo_rd_n = 1'b1;
    over_flow = 1'b0;
    err_clr = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one word for one cycle (caller ensures s_ready) and queue the
  // first n bytes that are expected to reach the FIFO.
  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_byte(w, i));
    s_data = w;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_wr_n", wr_n, 1);
    check("rst_din", din, 8'h00);
    check("rst_err", err, 0);
    check("rst_credits", credits, 16);
    check("rst_s_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, full credits
    @(negedge clk);
    base = wr_cnt;
    send_word(32'hA1B2C3D4, 4);
    check("busy_after_accept", s_ready, 0);
    wait_ready(lat);
    check("word_latency", lat, 4);
    @(negedge clk);
    check("word_writes", wr_cnt - base, 4);
    check("word_credits", credits, 12);

    // Exhaust credits, then stall
    do_reset();
    base = wr_cnt;
    send_word(32'h03020100, 4); wait_ready(lat);
    send_word(32'h07060504, 4); wait_ready(lat);
    send_word(32'h0B0A0908, 4); wait_ready(lat);
    send_word(32'h0F0E0D0C, 4); wait_ready(lat);
    @(negedge clk);
    check("fill_writes", wr_cnt - base, 16);
    check("fill_credits", credits, 0);
    check("fill_ready", s_ready, 1);
    base = wr_cnt;
    send_word(32'hDEADBEEF, 1);
    repeat (5) @(negedge clk);
    check("stall_writes", wr_cnt - base, 0);
    check("stall_ready", s_ready, 0);
    check("stall_credits", credits, 0);
    fifo_rd_n = 1'b0;
    @(negedge clk);
    fifo_rd_n = 1'b1;
    repeat (4) @(negedge clk);
    check("one_credit_writes", wr_cnt - base, 1);
    check("one_credit_credits", credits, 0);

    // Simultaneous issue and return at credits=5
    do_reset();
    send_word(32'h11111111, 4); wait_ready(lat);
    send_word(32'h22222222, 4); wait_ready(lat);
    send_word(32'h33445566, 4);
    repeat (3) @(negedge clk);
    check("pre_credits", credits, 5);
    fifo_rd_n = 1'b0;
    @(negedge clk);
    fifo_rd_n = 1'b1;
    check("issue_ret_credits", credits, 5);
    check("issue_ret_ready", s_ready, 1);

    // Reads while empty return nothing
    do_reset();
    base = wr_cnt;
    fifo_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    fifo_rd_n = 1'b1;
    check("underflow_credits", credits, 16);
    @(negedge clk);
    check("underflow_writes", wr_cnt - base, 0);

    // Overflow after the first byte
    do_reset();
    send_word(32'h0BADF00D, 1);
    @(negedge clk);
    over_flow = 1'b1;
    @(negedge clk);
    over_flow = 1'b0;
    check("ovf_err", err, 1);
    check("ovf_wr_n", wr_n, 1);
    check("ovf_ready", s_ready, 0);
    repeat (2) @(negedge clk);
    check("halt_ready", s_ready, 0);
    check("halt_wr_n", wr_n, 1);
    check("halt_credits", credits, 15);
    err_clr = 1'b1;
    over_flow = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    over_flow = 1'b0;
    check("clr_vs_ovf_err", err, 1);
    check("clr_vs_ovf_ready", s_ready, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", err, 0);
    check("clr_credits", credits, 16);
    check("clr_ready", s_ready, 1);

    // Reset in the middle of a word
    send_word(32'h11223344, 2);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_n", wr_n, 1);
    check("async_rst_credits", credits, 16);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_cnt;
    send_word(32'h55667788, 4);
    wait_ready(lat);
    @(negedge clk);
    check("post_rst_writes", wr_cnt - base, 4);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
